banner_sequencer: RTL and testbench

BANNER_SEQUENCER -- requirements
Module: banner_sequencer

---
 rtl/banner_sequencer_if.sv | 27 ++
 rtl/banner_sequencer.sv | 170 +++++++++++++++++
 tb/tb_banner_sequencer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/banner_sequencer_if.sv
// Banner sequencer bus: scan position, control pulses and the registered
// per-pixel tile outputs plus progress status.
interface banner_sequencer_if;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic        frame_tick;
  logic        start;
  logic        clear;
  logic        msg_sel;
  logic        tile_on;
  logic [3:0]  glyph;
  logic [5:0]  rom_addr;
  logic [5:0]  rom_col;
  logic [3:0]  revealed;
  logic        busy;
  logic        done;

  modport master (
    output pix_x, pix_y, frame_tick, start, clear, msg_sel,
    input  tile_on, glyph, rom_addr, rom_col, revealed, busy, done
  );

  modport slave (
    input  pix_x, pix_y, frame_tick, start, clear, msg_sel,
    output tile_on, glyph, rom_addr, rom_col, revealed, busy, done
  );
endinterface

// File: rtl/banner_sequencer.sv
// Banner sequencer: reveals an 8-slot "YOU WIN"/"YOU LOSE" tile row one slot
// every FRAMES_PER_TILE frames, holds it for HOLD_FRAMES frames, then stays
// steady until clear. Per-pixel outputs carry one cycle of latency.
// Optional feature: define BANNER_BLINK_EN to blink the row during HOLD.
module banner_sequencer #(
  parameter int X0              = 64,
  parameter int Y0              = 268,
  parameter int FRAMES_PER_TILE = 30,
  parameter int HOLD_FRAMES     = 120,
  parameter int BLINK_FRAMES    = 16
) (
  input logic               clk,
  input logic               rst_n,
  banner_sequencer_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REVEAL = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int CMAX = (FRAMES_PER_TILE > HOLD_FRAMES) ? FRAMES_PER_TILE : HOLD_FRAMES;
  localparam int CW   = $clog2(CMAX + 1);

  logic [1:0]    st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    rev, rev_n;
  logic          msg, msg_n;
  logic          gate_n;

  // Glyph table for both messages; slot 3 is the word gap.
  function automatic logic [3:0] glyph_of(input logic m, input logic [2:0] s);
    logic [3:0] g;
    case (s)
      3'd0:    g = 4'd1;
      3'd1:    g = 4'd2;
      3'd2:    g = 4'd3;
      3'd3:    g = 4'd0;
      3'd4:    g = m ? 4'd7 : 4'd4;
      3'd5:    g = m ? 4'd2 : 4'd5;
      3'd6:    g = m ? 4'd8 : 4'd6;
      default: g = m ? 4'd9 : 4'd0;
    endcase
    return g;
  endfunction

  // Window decode; offsets computed at full width then truncated.
  logic       in_win;
  logic [8:0] dx;
  logic [5:0] dy;
  logic [3:0] g_cur;
  assign in_win = ({1'b0, bus.pix_x} >= 12'(X0)) && ({1'b0, bus.pix_x} < 12'(X0 + 512)) &&
                  ({1'b0, bus.pix_y} >= 12'(Y0)) && ({1'b0, bus.pix_y} < 12'(Y0 + 64));
  assign dx     = 9'(bus.pix_x - 11'(X0));
  assign dy     = 6'(bus.pix_y - 11'(Y0));
  assign g_cur  = in_win ? glyph_of(msg_n, dx[8:6]) : 4'd0;

  // Sequencer next state; clear overrides everything, start only in IDLE.
  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    rev_n = rev;
    msg_n = msg;
    if (bus.clear) begin
      st_n  = IDLE;
      cnt_n = '0;
      rev_n = '0;
    end else begin
      case (st)
        IDLE: if (bus.start) begin
          st_n  = REVEAL;
          cnt_n = '0;
          rev_n = '0;
          msg_n = bus.msg_sel;
        end
        REVEAL: if (bus.frame_tick) begin
          if (cnt == CW'(FRAMES_PER_TILE - 1)) begin
            cnt_n = '0;
            rev_n = rev + 4'd1;
            if (rev == 4'd7) st_n = HOLD;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        HOLD: if (bus.frame_tick) begin
          if (cnt == CW'(HOLD_FRAMES - 1)) begin
            st_n  = DONE;
            cnt_n = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BANNER_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic          phase, phase_n;
  logic [BW-1:0] bcnt, bcnt_n;

  // Blink phase: set on HOLD entry, toggles every BLINK_FRAMES ticks in HOLD.
  always_comb begin
    phase_n = phase;
    bcnt_n  = bcnt;
    if (st_n == IDLE) begin
      phase_n = 1'b0;
      bcnt_n  = '0;
    end else if (st != HOLD && st_n == HOLD) begin
      phase_n = 1'b1;
      bcnt_n  = '0;
    end else if (st == HOLD && st_n == HOLD && bus.frame_tick) begin
      if (bcnt == BW'(BLINK_FRAMES - 1)) begin
        bcnt_n  = '0;
        phase_n = ~phase;
      end else begin
        bcnt_n = bcnt + 1'b1;
      end
    end
  end

  // Blink phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
      bcnt  <= '0;
    end else begin
      phase <= phase_n;
      bcnt  <= bcnt_n;
    end
  end

  assign gate_n = (st_n == HOLD) ? phase_n : 1'b1;
`else
  assign gate_n = 1'b1;
`endif

  // State, counters and all outputs; tile_on uses next-state so that start
  // and clear take effect on the same edge as the pixel they accompany.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= IDLE;
      cnt          <= '0;
      rev          <= '0;
      msg          <= 1'b0;
      bus.tile_on  <= 1'b0;
      bus.glyph    <= '0;
      bus.rom_addr <= '0;
      bus.rom_col  <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      st           <= st_n;
      cnt          <= cnt_n;
      rev          <= rev_n;
      msg          <= msg_n;
      bus.glyph    <= g_cur;
      bus.rom_addr <= dy;
      bus.rom_col  <= dx[5:0];
      bus.tile_on  <= in_win && ({1'b0, dx[8:6]} < rev_n) && (g_cur != 4'd0) &&
                      (st_n != IDLE) && gate_n;
      bus.busy     <= (st_n == REVEAL) || (st_n == HOLD);
      bus.done     <= (st_n == DONE);
    end
  end

  assign bus.revealed = rev;

endmodule

// File: tb/tb_banner_sequencer.sv
// Directed bench for banner_sequencer: reveal timing, pixel decode, hold,
// clear/start priority, latched message and asynchronous reset.
module tb_banner_sequencer;
  localparam int X0 = 64;
  localparam int Y0 = 268;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  banner_sequencer_if bus ();

  banner_sequencer #(
    .X0(X0), .Y0(Y0), .FRAMES_PER_TILE(30), .HOLD_FRAMES(120), .BLINK_FRAMES(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int gap);
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    repeat (gap - 1) step();
  endtask

  task automatic pulse_start(input logic m);
    bus.start   = 1'b1;
    bus.msg_sel = m;
    step();
    bus.start   = 1'b0;
  endtask

  task automatic set_pix(input int x, input int y);
    bus.pix_x = 11'(x);
    bus.pix_y = 11'(y);
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.pix_x = 11'(X0 + 10);
    bus.pix_y = 11'(Y0 + 3);
    bus.frame_tick = 1'b0; bus.start = 1'b0; bus.clear = 1'b0; bus.msg_sel = 1'b0;
    repeat (3) step();
    checks++; if (bus.tile_on !== 1'b0)  begin errors++; $display("FAIL rst_tile_on got %0d exp 0", bus.tile_on); end
    checks++; if (bus.glyph !== 4'd0)    begin errors++; $display("FAIL rst_glyph got %0d exp 0", bus.glyph); end
    checks++; if (bus.rom_addr !== 6'd0) begin errors++; $display("FAIL rst_rom_addr got %0d exp 0", bus.rom_addr); end
    checks++; if (bus.rom_col !== 6'd0)  begin errors++; $display("FAIL rst_rom_col got %0d exp 0", bus.rom_col); end
    checks++; if (bus.revealed !== 4'd0) begin errors++; $display("FAIL rst_revealed got %0d exp 0", bus.revealed); end
    checks++; if (bus.busy !== 1'b0)     begin errors++; $display("FAIL rst_busy got %0d exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0)     begin errors++; $display("FAIL rst_done got %0d exp 0", bus.done); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reveal();
    pulse_start(1'b0);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL start_busy got %0d exp 1", bus.busy); end
    for (int k = 1; k <= 240; k++) begin
      tick(100);
      if (k == 29) begin
        checks++; if (bus.revealed !== 4'd0) begin errors++; $display("FAIL rev_t29 got %0d exp 0", bus.revealed); end
      end
      if (k == 30) begin
        checks++; if (bus.revealed !== 4'd1) begin errors++; $display("FAIL rev_t30 got %0d exp 1", bus.revealed); end
      end
      if (k == 239) begin
        checks++; if (bus.revealed !== 4'd7) begin errors++; $display("FAIL rev_t239 got %0d exp 7", bus.revealed); end
      end
    end
    checks++; if (bus.revealed !== 4'd8) begin errors++; $display("FAIL rev_t240 got %0d exp 8", bus.revealed); end
    checks++; if (bus.busy !== 1'b1)     begin errors++; $display("FAIL hold_busy got %0d exp 1", bus.busy); end
    checks++; if (bus.done !== 1'b0)     begin errors++; $display("FAIL hold_done got %0d exp 0", bus.done); end
  endtask

  task automatic test_pixel();
    set_pix(X0 + 70, Y0 + 5);
    checks++; if (bus.glyph !== 4'd2)    begin errors++; $display("FAIL px70_glyph got %0d exp 2", bus.glyph); end
    checks++; if (bus.rom_col !== 6'd6)  begin errors++; $display("FAIL px70_col got %0d exp 6", bus.rom_col); end
    checks++; if (bus.rom_addr !== 6'd5) begin errors++; $display("FAIL px70_addr got %0d exp 5", bus.rom_addr); end
    checks++; if (bus.tile_on !== 1'b1)  begin errors++; $display("FAIL px70_tile got %0d exp 1", bus.tile_on); end
    set_pix(X0 + 200, Y0);
    checks++; if (bus.glyph !== 4'd0)    begin errors++; $display("FAIL px200_glyph got %0d exp 0", bus.glyph); end
    checks++; if (bus.tile_on !== 1'b0)  begin errors++; $display("FAIL px200_tile got %0d exp 0", bus.tile_on); end
    set_pix(X0 + 384, Y0 + 1);
    checks++; if (bus.glyph !== 4'd6)    begin errors++; $display("FAIL px384_glyph got %0d exp 6", bus.glyph); end
    checks++; if (bus.tile_on !== 1'b1)  begin errors++; $display("FAIL px384_tile got %0d exp 1", bus.tile_on); end
    set_pix(X0 + 511, Y0 + 63);
    checks++; if (bus.glyph !== 4'd0)     begin errors++; $display("FAIL px511_glyph got %0d exp 0", bus.glyph); end
    checks++; if (bus.rom_col !== 6'd63)  begin errors++; $display("FAIL px511_col got %0d exp 63", bus.rom_col); end
    checks++; if (bus.rom_addr !== 6'd63) begin errors++; $display("FAIL px511_addr got %0d exp 63", bus.rom_addr); end
    set_pix(X0 + 512, Y0);
    checks++; if (bus.glyph !== 4'd0)    begin errors++; $display("FAIL right_edge_glyph got %0d exp 0", bus.glyph); end
    set_pix(X0 - 1, Y0);
    checks++; if (bus.glyph !== 4'd0)    begin errors++; $display("FAIL left_edge_glyph got %0d exp 0", bus.glyph); end
    set_pix(X0 + 5, Y0 + 64);
    checks++; if (bus.glyph !== 4'd0)    begin errors++; $display("FAIL bottom_edge_glyph got %0d exp 0", bus.glyph); end
    checks++; if (bus.tile_on !== 1'b0)  begin errors++; $display("FAIL bottom_edge_tile got %0d exp 0", bus.tile_on); end
    set_pix(X0, Y0 - 1);
    checks++; if (bus.glyph !== 4'd0)    begin errors++; $display("FAIL top_edge_glyph got %0d exp 0", bus.glyph); end
  endtask

  task automatic test_start_busy();
    pulse_start(1'b1);
    set_pix(X0 + 256, Y0);
    checks++; if (bus.glyph !== 4'd4)    begin errors++; $display("FAIL busy_start_glyph got %0d exp 4", bus.glyph); end
    checks++; if (bus.busy !== 1'b1)     begin errors++; $display("FAIL busy_start_busy got %0d exp 1", bus.busy); end
    checks++; if (bus.revealed !== 4'd8) begin errors++; $display("FAIL busy_start_rev got %0d exp 8", bus.revealed); end
  endtask

  task automatic test_hold();
    logic exp_dark;
`ifdef BANNER_BLINK_EN
    exp_dark = 1'b0;
`else
    exp_dark = 1'b1;
`endif
    set_pix(X0 + 70, Y0 + 5);
    for (int k = 1; k <= 120; k++) begin
      tick(4);
      if (k == 8) begin
        checks++; if (bus.tile_on !== 1'b1) begin errors++; $display("FAIL hold_t8_tile got %0d exp 1", bus.tile_on); end
      end
      if (k == 20) begin
        checks++; if (bus.tile_on !== exp_dark) begin errors++; $display("FAIL hold_t20_tile got %0d exp %0d", bus.tile_on, exp_dark); end
      end
      if (k == 40) begin
        checks++; if (bus.tile_on !== 1'b1) begin errors++; $display("FAIL hold_t40_tile got %0d exp 1", bus.tile_on); end
      end
      if (k == 119) begin
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL hold_t119_done got %0d exp 0", bus.done); end
      end
    end
    checks++; if (bus.done !== 1'b1)     begin errors++; $display("FAIL done_done got %0d exp 1", bus.done); end
    checks++; if (bus.busy !== 1'b0)     begin errors++; $display("FAIL done_busy got %0d exp 0", bus.busy); end
    for (int k = 0; k < 20; k++) tick(4);
    checks++; if (bus.tile_on !== 1'b1)  begin errors++; $display("FAIL done_tile got %0d exp 1", bus.tile_on); end
    checks++; if (bus.revealed !== 4'd8) begin errors++; $display("FAIL done_rev got %0d exp 8", bus.revealed); end
    checks++; if (bus.done !== 1'b1)     begin errors++; $display("FAIL done_stay got %0d exp 1", bus.done); end
  endtask

  task automatic test_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    checks++; if (bus.revealed !== 4'd0) begin errors++; $display("FAIL clr_rev got %0d exp 0", bus.revealed); end
    checks++; if (bus.tile_on !== 1'b0)  begin errors++; $display("FAIL clr_tile got %0d exp 0", bus.tile_on); end
    checks++; if (bus.done !== 1'b0)     begin errors++; $display("FAIL clr_done got %0d exp 0", bus.done); end
    checks++; if (bus.busy !== 1'b0)     begin errors++; $display("FAIL clr_busy got %0d exp 0", bus.busy); end
  endtask

  task automatic test_clear_start();
    bus.clear = 1'b1; bus.start = 1'b1; bus.msg_sel = 1'b1;
    step();
    bus.clear = 1'b0; bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clrstart_busy got %0d exp 0", bus.busy); end
    for (int k = 0; k < 35; k++) tick(2);
    checks++; if (bus.revealed !== 4'd0) begin errors++; $display("FAIL clrstart_rev got %0d exp 0", bus.revealed); end
    checks++; if (bus.busy !== 1'b0)     begin errors++; $display("FAIL clrstart_idle got %0d exp 0", bus.busy); end
  endtask

  task automatic test_tick_start_msg1();
    bus.start = 1'b1; bus.frame_tick = 1'b1; bus.msg_sel = 1'b1;
    step();
    bus.start = 1'b0; bus.frame_tick = 1'b0;
    bus.msg_sel = 1'b0;
    for (int k = 1; k <= 29; k++) tick(2);
    checks++; if (bus.revealed !== 4'd0) begin errors++; $display("FAIL tickstart_t29 got %0d exp 0", bus.revealed); end
    tick(2);
    checks++; if (bus.revealed !== 4'd1) begin errors++; $display("FAIL tickstart_t30 got %0d exp 1", bus.revealed); end
    set_pix(X0 + 70, Y0 + 5);
    checks++; if (bus.tile_on !== 1'b0) begin errors++; $display("FAIL rev1_slot1_tile got %0d exp 0", bus.tile_on); end
    checks++; if (bus.glyph !== 4'd2)   begin errors++; $display("FAIL rev1_slot1_glyph got %0d exp 2", bus.glyph); end
    set_pix(X0 + 10, Y0);
    checks++; if (bus.tile_on !== 1'b1) begin errors++; $display("FAIL rev1_slot0_tile got %0d exp 1", bus.tile_on); end
    for (int k = 31; k <= 240; k++) tick(2);
    set_pix(X0 + 256, Y0);
    checks++; if (bus.glyph !== 4'd7)   begin errors++; $display("FAIL lose_slot4_glyph got %0d exp 7", bus.glyph); end
    set_pix(X0 + 511, Y0 + 63);
    checks++; if (bus.glyph !== 4'd9)   begin errors++; $display("FAIL lose_slot7_glyph got %0d exp 9", bus.glyph); end
    checks++; if (bus.tile_on !== 1'b1) begin errors++; $display("FAIL lose_slot7_tile got %0d exp 1", bus.tile_on); end
    set_pix(X0 + 320, Y0);
    checks++; if (bus.glyph !== 4'd2)   begin errors++; $display("FAIL lose_slot5_glyph got %0d exp 2", bus.glyph); end
  endtask

  task automatic test_reset_mid();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    pulse_start(1'b0);
    for (int k = 0; k < 150; k++) tick(2);
    checks++; if (bus.revealed !== 4'd5) begin errors++; $display("FAIL mid_rev got %0d exp 5", bus.revealed); end
    set_pix(X0 + 10, Y0 + 2);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.revealed !== 4'd0) begin errors++; $display("FAIL async_rev got %0d exp 0", bus.revealed); end
    checks++; if (bus.tile_on !== 1'b0)  begin errors++; $display("FAIL async_tile got %0d exp 0", bus.tile_on); end
    checks++; if (bus.glyph !== 4'd0)    begin errors++; $display("FAIL async_glyph got %0d exp 0", bus.glyph); end
    checks++; if (bus.rom_addr !== 6'd0) begin errors++; $display("FAIL async_addr got %0d exp 0", bus.rom_addr); end
    checks++; if (bus.busy !== 1'b0)     begin errors++; $display("FAIL async_busy got %0d exp 0", bus.busy); end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) tick(2);
    checks++; if (bus.revealed !== 4'd0) begin errors++; $display("FAIL post_rst_rev got %0d exp 0", bus.revealed); end
    checks++; if (bus.busy !== 1'b0)     begin errors++; $display("FAIL post_rst_busy got %0d exp 0", bus.busy); end
    checks++; if (bus.tile_on !== 1'b0)  begin errors++; $display("FAIL post_rst_tile got %0d exp 0", bus.tile_on); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_reveal();
    test_pixel();
    test_start_busy();
    test_hold();
    test_clear();
    test_clear_start();
    test_tick_start_msg1();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
